// File: rtl/fft_bin_quantizer.sv
// Converts complex FFT bins into log-magnitude codes over a 3-stage pipeline and tracks bin order.
// Optional per-frame peak reporting is built when FFT_BIN_QUANTIZER_PEAK_EN is defined.
module fft_bin_quantizer #(
    parameter int WORD_WIDTH = 16,
    parameter int FFT_SIZE   = 128,
    parameter int OUT_WIDTH  = 4,
    parameter int LOG_OFFSET = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [$clog2(FFT_SIZE/2)-1:0]   in_idx,
    input  logic [2*WORD_WIDTH-1:0]         in_data,
    output logic                            out_valid,
    output logic [$clog2(FFT_SIZE/2)-1:0]   out_idx,
    output logic [OUT_WIDTH-1:0]            out_data,
    output logic                            frame_done,
    output logic                            desync
`ifdef FFT_BIN_QUANTIZER_PEAK_EN
    ,
    output logic [$clog2(FFT_SIZE/2)-1:0]   peak_idx,
    output logic [OUT_WIDTH-1:0]            peak_code
`endif
);

    localparam int IDX_W    = $clog2(FFT_SIZE/2);
    localparam int MAG_W    = WORD_WIDTH + 1;
    localparam int CODE_MAX = (1 << OUT_WIDTH) - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_SIZE/2 - 1);

    // Valid-only streaming: a bin is transferred on every cycle in_valid is high and
    // appears on out_valid exactly three cycles later; there is no ready/back-pressure.

    logic                  s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0]      s1_idx_q,   s1_idx_d;
    logic [WORD_WIDTH-1:0] s1_re_q,    s1_re_d;
    logic [WORD_WIDTH-1:0] s1_im_q,    s1_im_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [IDX_W-1:0]      s2_idx_q,   s2_idx_d;
    logic [MAG_W-1:0]      s2_mag_q,   s2_mag_d;

    logic                  out_valid_q,  out_valid_d;
    logic [IDX_W-1:0]      out_idx_q,    out_idx_d;
    logic [OUT_WIDTH-1:0]  out_data_q,   out_data_d;
    logic                  frame_done_q, frame_done_d;

    logic [IDX_W-1:0]      exp_idx_q, exp_idx_d;
    logic                  desync_q,  desync_d;

    logic [WORD_WIDTH-1:0] mx_c;
    logic [WORD_WIDTH-1:0] mn_c;
    logic [OUT_WIDTH-1:0]  code_c;
    int                    code_lvl;

    function automatic logic [WORD_WIDTH-1:0] abs_w(input logic [WORD_WIDTH-1:0] v);
        // The most negative value wraps to 2^(W-1), which is still exact as unsigned.
        abs_w = v[WORD_WIDTH-1] ? ((~v) + WORD_WIDTH'(1)) : v;
    endfunction

    function automatic int msb_pos(input logic [MAG_W-1:0] v);
        msb_pos = 0;
        for (int i = 0; i < MAG_W; i++) begin
            if (v[i]) begin
                msb_pos = i;
            end
        end
    endfunction

    always_comb begin
        s1_valid_d = in_valid;
        s1_idx_d   = s1_idx_q;
        s1_re_d    = s1_re_q;
        s1_im_d    = s1_im_q;
        if (in_valid) begin
            s1_idx_d = in_idx;
            s1_re_d  = abs_w(in_data[2*WORD_WIDTH-1:WORD_WIDTH]);
            s1_im_d  = abs_w(in_data[WORD_WIDTH-1:0]);
        end
    end

    always_comb begin
        mx_c       = (s1_re_q >= s1_im_q) ? s1_re_q : s1_im_q;
        mn_c       = (s1_re_q >= s1_im_q) ? s1_im_q : s1_re_q;
        s2_valid_d = s1_valid_q;
        s2_idx_d   = s2_idx_q;
        s2_mag_d   = s2_mag_q;
        if (s1_valid_q) begin
            s2_idx_d = s1_idx_q;
            s2_mag_d = MAG_W'(mx_c) + MAG_W'(mn_c >> 2) + MAG_W'(mn_c >> 3);
        end
    end

    always_comb begin
        code_c   = '0;
        code_lvl = 0;
        if (s2_mag_q != '0) begin
            code_lvl = msb_pos(s2_mag_q) + 1 - LOG_OFFSET;
            if (code_lvl < 0) begin
                code_c = '0;
            end else if (code_lvl > CODE_MAX) begin
                code_c = OUT_WIDTH'(CODE_MAX);
            end else begin
                code_c = OUT_WIDTH'(code_lvl);
            end
        end
    end

    always_comb begin
        out_valid_d  = s2_valid_q;
        out_idx_d    = out_idx_q;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;
        if (s2_valid_q) begin
            out_idx_d    = s2_idx_q;
            out_data_d   = code_c;
            frame_done_d = (s2_idx_q == LAST_IDX);
        end
    end

    // The expected index always follows the observed one, so a single skip flags once.
    always_comb begin
        exp_idx_d = exp_idx_q;
        desync_d  = desync_q;
        if (in_valid) begin
            if (in_idx != exp_idx_q) begin
                desync_d = 1'b1;
            end
            exp_idx_d = (in_idx == LAST_IDX) ? '0 : (in_idx + IDX_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q   <= 1'b0;
            s1_idx_q     <= '0;
            s1_re_q      <= '0;
            s1_im_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_idx_q     <= '0;
            s2_mag_q     <= '0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
            exp_idx_q    <= '0;
            desync_q     <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_idx_q     <= s1_idx_d;
            s1_re_q      <= s1_re_d;
            s1_im_q      <= s1_im_d;
            s2_valid_q   <= s2_valid_d;
            s2_idx_q     <= s2_idx_d;
            s2_mag_q     <= s2_mag_d;
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
            exp_idx_q    <= exp_idx_d;
            desync_q     <= desync_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;
    assign desync     = desync_q;

`ifdef FFT_BIN_QUANTIZER_PEAK_EN
    logic                 run_vld_q,   run_vld_d;
    logic [IDX_W-1:0]     run_idx_q,   run_idx_d;
    logic [OUT_WIDTH-1:0] run_code_q,  run_code_d;
    logic [IDX_W-1:0]     peak_idx_q,  peak_idx_d;
    logic [OUT_WIDTH-1:0] peak_code_q, peak_code_d;
    logic                 cand_better;

    // The bin leaving stage 3 is folded in on the same edge it is published, so the
    // frame's final bin takes part in the peak reported with frame_done.
    always_comb begin
        cand_better = !run_vld_q || (code_c > run_code_q) ||
                      ((code_c == run_code_q) && (s2_idx_q < run_idx_q));
        run_vld_d   = run_vld_q;
        run_idx_d   = run_idx_q;
        run_code_d  = run_code_q;
        peak_idx_d  = peak_idx_q;
        peak_code_d = peak_code_q;
        if (s2_valid_q) begin
            if (s2_idx_q == LAST_IDX) begin
                peak_idx_d  = cand_better ? s2_idx_q : run_idx_q;
                peak_code_d = cand_better ? code_c   : run_code_q;
                run_vld_d   = 1'b0;
                run_idx_d   = '0;
                run_code_d  = '0;
            end else if (cand_better) begin
                run_vld_d  = 1'b1;
                run_idx_d  = s2_idx_q;
                run_code_d = code_c;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_vld_q   <= 1'b0;
            run_idx_q   <= '0;
            run_code_q  <= '0;
            peak_idx_q  <= '0;
            peak_code_q <= '0;
        end else begin
            run_vld_q   <= run_vld_d;
            run_idx_q   <= run_idx_d;
            run_code_q  <= run_code_d;
            peak_idx_q  <= peak_idx_d;
            peak_code_q <= peak_code_d;
        end
    end

    assign peak_idx  = peak_idx_q;
    assign peak_code = peak_code_q;
`endif

endmodule

// File: tb/tb_fft_bin_quantizer.sv
// Randomised scoreboard bench for fft_bin_quantizer; the peak outputs are checked when
// FFT_BIN_QUANTIZER_PEAK_EN is defined.
module tb_fft_bin_quantizer;

    localparam int WORD_WIDTH = 16;
    localparam int FFT_SIZE   = 128;
    localparam int OUT_WIDTH  = 4;
    localparam int LOG_OFFSET = 1;
    localparam int IDX_W      = 6;
    localparam int NBINS      = FFT_SIZE / 2;
    localparam int LATENCY    = 3;
    localparam int EXP_W      = 2 * IDX_W + 2 * OUT_WIDTH + 1;

    // ---------------- clock / reset ----------------
    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    in_valid = 1'b0;
    logic [IDX_W-1:0]        in_idx = '0;
    logic [2*WORD_WIDTH-1:0] in_data = '0;
    logic                    out_valid;
    logic [IDX_W-1:0]        out_idx;
    logic [OUT_WIDTH-1:0]    out_data;
    logic                    frame_done;
    logic                    desync;
`ifdef FFT_BIN_QUANTIZER_PEAK_EN
    logic [IDX_W-1:0]        peak_idx;
    logic [OUT_WIDTH-1:0]    peak_code;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fft_bin_quantizer #(
        .WORD_WIDTH(WORD_WIDTH), .FFT_SIZE(FFT_SIZE),
        .OUT_WIDTH(OUT_WIDTH), .LOG_OFFSET(LOG_OFFSET)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_idx(in_idx), .in_data(in_data),
        .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
        .frame_done(frame_done), .desync(desync)
`ifdef FFT_BIN_QUANTIZER_PEAK_EN
        , .peak_idx(peak_idx), .peak_code(peak_code)
`endif
    );

    // ---------------- scoreboard state ----------------
    // expectation layout: {peak_idx, peak_code, frame_done, idx, code}
    logic [EXP_W-1:0] exp_q[$];
    int               exp_t_q[$];
    logic [9:0]       frame_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int model_exp = 0;
    bit model_desync = 1'b0;
    int pub_idx = 0, pub_code = 0;
    int last_idx = 0, last_code = 0, last_pk_idx = 0, last_pk_code = 0;
    logic [EXP_W-1:0] mon_e;
    int mon_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // Reference: integer magnitude estimate, then floor(log2) found by counting halvings.
    function automatic int ref_code(input int re, input int im);
        int a, b, mx, mn, mag, p, c;
        a = (re < 0) ? -re : re;
        b = (im < 0) ? -im : im;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        mag = mx + mn / 4 + mn / 8;
        if (mag == 0) return 0;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        c = p + 1 - LOG_OFFSET;
        if (c < 0) c = 0;
        if (c > (1 << OUT_WIDTH) - 1) c = (1 << OUT_WIDTH) - 1;
        return c;
    endfunction

    function automatic int rand_comp();
        case ($urandom_range(0, 3))
            0: return int'($urandom_range(0, 65535)) - 32768;
            1: return int'($urandom_range(0, 16)) - 8;
            2: return ($urandom_range(0, 1) == 1) ? -32768 : 32767;
            default: return (int'($urandom_range(0, 65535)) - 32768) >>> $urandom_range(0, 15);
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_bin(input int idx, input int re, input int im);
        int code;
        int bi, bc, ci, cc;
        bit fd;
        logic [EXP_W-1:0] e;
        @(negedge clk); #1;
        chk("desync", desync, model_desync);
        in_valid = 1'b1;
        in_idx   = IDX_W'(idx);
        in_data  = {re[15:0], im[15:0]};
        if (idx != model_exp) model_desync = 1'b1;
        model_exp = (idx + 1) % NBINS;
        code = ref_code(re, im);
        frame_q.push_back({idx[5:0], code[3:0]});
        fd = (idx == NBINS - 1);
        if (fd) begin
            bi = -1;
            bc = -1;
            foreach (frame_q[k]) begin
                ci = int'(frame_q[k][9:4]);
                cc = int'(frame_q[k][3:0]);
                if (cc > bc || (cc == bc && ci < bi)) begin
                    bc = cc;
                    bi = ci;
                end
            end
            pub_idx  = bi;
            pub_code = bc;
            frame_q.delete();
        end
        e = {pub_idx[5:0], pub_code[3:0], fd, idx[5:0], code[3:0]};
        exp_q.push_back(e);
        exp_t_q.push_back(cyc + LATENCY);
    endtask

    task automatic drive_idle();
        @(negedge clk); #1;
        chk("desync", desync, model_desync);
        in_valid = 1'b0;
        in_idx   = IDX_W'($urandom_range(0, NBINS - 1));
        in_data  = $urandom;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        exp_t_q.delete();
        frame_q.delete();
        model_exp    = 0;
        model_desync = 1'b0;
        pub_idx = 0; pub_code = 0;
        last_idx = 0; last_code = 0; last_pk_idx = 0; last_pk_code = 0;
        repeat (cycles) begin
            @(negedge clk); #1;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_idx", out_idx, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_desync", desync, 0);
`ifdef FFT_BIN_QUANTIZER_PEAK_EN
            chk("rst_peak_idx", peak_idx, 0);
            chk("rst_peak_code", peak_code, 0);
`endif
        end
        reset = 1'b1;
    endtask

    task automatic random_frame(input int gap_pct);
        for (int i = 0; i < NBINS; i++) begin
            while ($urandom_range(0, 99) < gap_pct) drive_idle();
            drive_bin(i, rand_comp(), rand_comp());
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_t = exp_t_q.pop_front();
                    chk("latency", cyc, mon_t);
                    chk("out_idx", out_idx, int'(mon_e[9:4]));
                    chk("out_data", out_data, int'(mon_e[3:0]));
                    chk("frame_done", frame_done, int'(mon_e[10]));
                    last_idx     = int'(mon_e[9:4]);
                    last_code    = int'(mon_e[3:0]);
                    last_pk_code = int'(mon_e[14:11]);
                    last_pk_idx  = int'(mon_e[20:15]);
`ifdef FFT_BIN_QUANTIZER_PEAK_EN
                    chk("peak_idx", peak_idx, last_pk_idx);
                    chk("peak_code", peak_code, last_pk_code);
`endif
                end
            end else begin
                chk("frame_done_idle", frame_done, 0);
                chk("out_idx_hold", out_idx, last_idx);
                chk("out_data_hold", out_data, last_code);
`ifdef FFT_BIN_QUANTIZER_PEAK_EN
                chk("peak_idx_hold", peak_idx, last_pk_idx);
                chk("peak_code_hold", peak_code, last_pk_code);
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        do_reset(3);
        repeat (2) drive_idle();

        // directed single bins with gaps
        drive_bin(0, 256, 0);        drive_idle(); drive_idle();
        drive_bin(1, -3, 4);         drive_idle(); drive_idle();
        drive_bin(2, 0, 0);          drive_idle(); drive_idle();
        drive_bin(3, -32768, -32768); drive_idle(); drive_idle();

        // valid toggling 1,0,1,0 to finish the frame
        for (int i = 4; i < NBINS; i++) begin
            drive_bin(i, rand_comp(), rand_comp());
            drive_idle();
        end

        // two frames back to back, no gaps
        random_frame(0);
        random_frame(0);

        // peak frame then all-zero frame
        for (int i = 0; i < NBINS; i++)
            drive_bin(i, (i == 10 || i == 40) ? 256 : 0, 0);
        for (int i = 0; i < NBINS; i++)
            drive_bin(i, 0, 0);

        // index skip 2 -> 5, then in-sequence continuation
        drive_bin(0, rand_comp(), rand_comp());
        drive_bin(1, rand_comp(), rand_comp());
        drive_bin(2, rand_comp(), rand_comp());
        for (int i = 5; i < NBINS; i++)
            drive_bin(i, rand_comp(), rand_comp());

        random_frame(30);

        // reset with bins in flight
        drive_bin(0, rand_comp(), rand_comp());
        drive_bin(1, rand_comp(), rand_comp());
        drive_bin(2, rand_comp(), rand_comp());
        do_reset(3);
        repeat (2) drive_idle();
        random_frame(20);

        repeat (4) drive_idle();
        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("drain_empty", exp_q.size(), 0);
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_bin_quantizer.md
Name: fft_bin_quantizer

Overview:
- Sits between the FFT/input-processing stage and the display manager.
- Converts each complex FFT bin (real/imag, WORD_WIDTH each) into an OUT_WIDTH-bit log-magnitude code for the spectrogram RAM.
- 3-stage pipeline, one bin per clock. No back-pressure.
- Also tracks bin sequence, flags frame completion and index desync.

Parameters:
- WORD_WIDTH, 16, width of each real/imag component (signed two's complement)
- FFT_SIZE, 128, FFT length; FFT_SIZE/2 bins per frame
- OUT_WIDTH, 4, width of the quantized magnitude code
- LOG_OFFSET, 1, subtracted from the leading-one position before saturation

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  bin present on in_idx/in_data this cycle
- in_idx  in  $clog2(FFT_SIZE/2)  bin index
- in_data  in  2*WORD_WIDTH  {real[2W-1:W], imag[W-1:0]}, signed
- out_valid  out  1  quantized bin valid
- out_idx  out  $clog2(FFT_SIZE/2)  bin index, delayed with data
- out_data  out  OUT_WIDTH  log-magnitude code
- frame_done  out  1  one-cycle pulse with out_valid of bin FFT_SIZE/2-1
- desync  out  1  sticky: an input index arrived out of sequence

Behaviour:
- Reset (reset low, async): all outputs 0, pipeline valids 0, expected-index counter 0, desync 0. Reset mid-frame discards in-flight bins; no out_valid until 3 cycles after the first post-reset in_valid.
- Latency: exactly 3 clocks from in_valid to out_valid. Idx travels with data. Gaps in in_valid produce matching gaps in out_valid.
- S1: abs of real and imag as unsigned WORD_WIDTH bits. -2^(W-1) maps to 2^(W-1), with no saturation.
- S2: mx = max(|re|,|im|), mn = min. mag = mx + (mn>>2) + (mn>>3), width WORD_WIDTH+1. Cannot overflow.
- S3: p = position of the leading one of mag.
  - mag == 0 -> code 0.
  - Otherwise code = clamp(p + 1 - LOG_OFFSET, 0, 2^OUT_WIDTH - 1).
- Sequence tracking at input, on each in_valid:
  - If in_idx != expected, set desync (sticky until reset).
  - Expected becomes in_idx+1, wrapping FFT_SIZE/2-1 -> 0. The counter always resyncs to the observed index.
- frame_done is asserted when out_valid && out_idx == FFT_SIZE/2-1, regardless of desync.
- Back-to-back bins every cycle are supported indefinitely. The last bin of frame N and bin 0 of frame N+1 may be adjacent.
- Outputs are registered. out_data/out_idx hold their last value when out_valid = 0.

Optional Feature:
- Macro: FFT_BIN_QUANTIZER_PEAK_EN.
- When defined:
  - Extra outputs peak_idx ($clog2(FFT_SIZE/2)) and peak_code (OUT_WIDTH).
  - A running max of out_data over the frame is kept; ties keep the lowest index.
  - On the frame_done cycle, peak_idx/peak_code update to the frame's peak, including the final bin. They hold until the next frame_done.
  - The running max clears after frame_done. Reset value is 0.
- When undefined: these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset low mid-stream with bins in flight, then release -> outputs 0 during reset. First out_valid exactly 3 cycles after first new in_valid. desync = 0.
- Single bins (one per frame slot):
  - re=256, im=0 -> code 8.
  - re=-3, im=4 -> mag 4, code 2.
  - re=im=0 -> code 0.
  - re=im=-32768 -> mag 45056, code 15.
  - Each appears 3 cycles later with correct out_idx.
- Continuous bins 0..63 for two frames back-to-back -> 128 consecutive out_valid cycles. frame_done high only on the two idx=63 cycles. desync stays 0.
- Sequence 0,1,2,5,6 -> desync rises on the cycle after idx 5 is sampled and stays high. Next expected after 6 is 7, so a following 7 causes no further error.
- in_valid toggling 1,0,1,0 -> out_valid shows the identical pattern 3 cycles later. out_data holds between valids.
- With FFT_BIN_QUANTIZER_PEAK_EN, frame of zeros except bin 10 = re 256 (code 8) and bin 40 = re 256 -> peak_idx=10, peak_code=8 at frame_done. Next frame all zeros -> peak_idx=0, peak_code=0.
